// File: rtl/apb_dpmem_pkg.sv
// Shared types and constants for the APB dual-port wait-state memory.
package apb_dpmem_pkg;

    // Transfer tracking states. SETUP is the point right after a completed
    // transfer, where a back-to-back setup phase may arrive.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Largest number of wait states the 4-bit counter can hold.
    localparam int unsigned MAX_WAIT = 32'd15;

    // Number of byte lanes in a data word of width dw.
    function automatic int unsigned lanes(input int unsigned dw);
        return dw / 32'd8;
    endfunction

endpackage

// File: rtl/dpmem_bank.sv
// DEPTH x DATA_WIDTH storage: byte-enabled write and registered read on
// port A, independent registered read-first port B.
module dpmem_bank
    import apb_dpmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_we,
    input  logic [DATA_WIDTH/8-1:0]      a_strb,
    input  logic [$clog2(DEPTH)-1:0]     a_idx,
    input  logic [DATA_WIDTH-1:0]        a_wdata,
    input  logic                         a_re,
    input  logic                         a_zero,
    output logic [DATA_WIDTH-1:0]        a_rdata,
    input  logic                         b_en,
    input  logic [$clog2(DEPTH)-1:0]     b_idx,
    output logic [DATA_WIDTH-1:0]        b_rdata
);

    localparam int unsigned LANES = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] a_rdata_r;
    logic [DATA_WIDTH-1:0] b_rdata_r;
    logic                  a_hit_s;
    logic                  b_hit_s;

    // The index ports are wider than needed when DEPTH is not a power of two.
    assign a_hit_s = (32'(a_idx) < DEPTH);
    assign b_hit_s = (32'(b_idx) < DEPTH);

    // Byte-enabled commit on port A; reset cycles and stray indices never touch the array
    always_ff @(posedge clk) begin
        if (rst_n && a_we && a_hit_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_strb[i]) begin
                    mem_r[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Port A read register: loads on request (zero for errored transfers), otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (a_re) begin
            if (a_zero || !a_hit_s) begin
                a_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
                a_rdata_r <= mem_r[a_idx];
            end
        end
    end

    // Port B read register: read-first against a same-edge port A write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (b_en) begin
            if (b_hit_s) begin
                b_rdata_r <= mem_r[b_idx];
            end else begin
                b_rdata_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign a_rdata = a_rdata_r;
    assign b_rdata = b_rdata_r;

endmodule

// File: rtl/apb_dpmem_ws.sv
// APB slave memory with programmable wait states, byte strobes, error
// response and a local read-only port B.
module apb_dpmem_ws
    import apb_dpmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      b_en,
    input  logic [$clog2(DEPTH)-1:0]  b_addr,
    output logic [DATA_WIDTH-1:0]     b_rdata
);

    localparam int unsigned LANES = lanes(DATA_WIDTH);
    localparam int unsigned LSB   = $clog2(LANES);
    localparam int unsigned IW    = ADDR_WIDTH - LSB;
    localparam int unsigned AW    = $clog2(DEPTH);
    // Out-of-range settings saturate at the counter's capacity.
    localparam logic [3:0]  WAIT_L = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);

    apb_state_e     state_r;
    logic [3:0]     cnt_r;
    logic           pready_r;
    logic           pslverr_r;
    logic           err_r;

    logic [IW-1:0]  word_idx_s;
    logic [AW-1:0]  bank_idx_s;
    logic           misalign_s;
    logic           range_err_s;
    logic           err_s;
    logic           setup_s;
    logic           cap_s;
    logic           we_s;

    assign word_idx_s = PADDR[ADDR_WIDTH-1:LSB];
    assign bank_idx_s = AW'(word_idx_s);

    // Byte-wide words have no sub-word address bits to misalign.
    generate
        if (LSB > 0) begin : g_align
            assign misalign_s = |PADDR[LSB-1:0];
        end else begin : g_no_align
            assign misalign_s = 1'b0;
        end
    endgenerate

    assign range_err_s = (32'(word_idx_s) >= DEPTH);
    assign err_s       = range_err_s | misalign_s;

    // A setup phase is accepted whenever no access phase is in progress.
    assign setup_s = PSEL & ~PENABLE & (state_r != ACCESS);
    // Reads capture array data at setup; errored transfers force PRDATA to zero.
    assign cap_s   = setup_s & (~PWRITE | err_s);
    // Writes commit only on the completing edge of a clean transfer.
    assign we_s    = (state_r == ACCESS) & pready_r & PSEL & PENABLE & PWRITE & ~err_r;

    // Transfer FSM with wait counter and registered PREADY/PSLVERR
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, SETUP: begin
                    if (setup_s) begin
                        state_r   <= ACCESS;
                        cnt_r     <= WAIT_L;
                        err_r     <= err_s;
                        pready_r  <= (WAIT_L == 4'd0);
                        pslverr_r <= (WAIT_L == 4'd0) & err_s;
                    end else begin
                        state_r   <= IDLE;
                        cnt_r     <= 4'd0;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer: drop it silently.
                        state_r   <= IDLE;
                        cnt_r     <= 4'd0;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end else if (pready_r) begin
                        state_r   <= SETUP;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r - 4'd1;
                        pready_r  <= (cnt_r == 4'd1);
                        pslverr_r <= (cnt_r == 4'd1) & err_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 4'd0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    err_r     <= 1'b0;
                end
            endcase
        end
    end

    dpmem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .a_we    (we_s),
        .a_strb  (PSTRB),
        .a_idx   (bank_idx_s),
        .a_wdata (PWDATA),
        .a_re    (cap_s),
        .a_zero  (err_s),
        .a_rdata (PRDATA),
        .b_en    (b_en),
        .b_idx   (b_addr),
        .b_rdata (b_rdata)
    );

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_dpmem_ws.sv
// Scoreboard bench: dut0 has no wait states and 200 words, dut3 has three
// wait states and 256 words; both share the APB data/address wires and port B.
module tb_apb_dpmem_ws;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel0, psel3, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        b_en;
    logic [7:0]  b_addr;
    logic [31:0] prdata0, prdata3, brd0, brd3;
    logic        pready0, pready3, pslverr0, pslverr3;

    typedef struct {
        int          d;
        logic        wr;
        logic        err;
        logic [31:0] data;
        int          waits;
        logic [11:0] addr;
    } apb_exp_t;

    typedef struct {
        int          d;
        logic [31:0] v;
    } b_exp_t;

    apb_exp_t aq[$];
    b_exp_t   bq[$];
    int       n_checks = 0;
    int       n_err    = 0;
    int       wcnt0    = 0;
    int       wcnt3    = 0;
    logic     b_seen   = 1'b0;

    always #5 clk = ~clk;

    apb_dpmem_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(200), .WAIT_CYCLES(0)) dut0 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .b_en(b_en), .b_addr(b_addr), .b_rdata(brd0)
    );

    apb_dpmem_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3), .b_en(b_en), .b_addr(b_addr), .b_rdata(brd3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_apb(input int d, input logic [31:0] rd, input logic err, input int w);
        apb_exp_t e;
        if (aq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL apb_unexpected: dut%0d completed a transfer, expected none", d);
        end else begin
            e = aq.pop_front();
            chk($sformatf("dut_id@%0h", e.addr), 32'(d), 32'(e.d));
            chk($sformatf("pslverr_dut%0d@%0h", d, e.addr), 32'(err), 32'(e.err));
            if (!e.wr || e.err) chk($sformatf("prdata_dut%0d@%0h", d, e.addr), rd, e.data);
            chk($sformatf("waits_dut%0d@%0h", d, e.addr), 32'(w), 32'(e.waits));
        end
    endtask

    // Remember which edges sampled a port-B request
    always @(posedge clk) b_seen <= b_en;

    // Monitor: compare every completed APB transfer and every port-B result
    always @(negedge clk) begin
        b_exp_t be;
        if (psel0 && penable) begin
            if (pready0) begin check_apb(0, prdata0, pslverr0, wcnt0); wcnt0 = 0; end
            else wcnt0++;
        end else wcnt0 = 0;
        if (psel3 && penable) begin
            if (pready3) begin check_apb(3, prdata3, pslverr3, wcnt3); wcnt3 = 0; end
            else wcnt3++;
        end else wcnt3 = 0;
        if (b_seen) begin
            if (bq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL portb_unexpected: result with no expectation queued");
            end else begin
                be = bq.pop_front();
                chk($sformatf("portb_dut%0d", be.d), (be.d == 0) ? brd0 : brd3, be.v);
            end
        end
    end

    task automatic apb(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic e_err, input logic [31:0] e_data);
        apb_exp_t e;
        apb_exp_t dummy;
        logic     done = 1'b0;
        e.d = d; e.wr = wr; e.err = e_err; e.data = e_data; e.addr = a;
        e.waits = (d == 0) ? 0 : 3;
        aq.push_back(e);
        @(posedge clk); #1;
        psel0 = (d == 0); psel3 = (d != 0); penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = (d == 0) ? pready0 : pready3;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL apb_timeout dut%0d@%0h: PREADY stayed 0, expected 1 within 20 cycles", d, a);
            dummy = aq.pop_back();
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic bpush(input int d, input logic [31:0] v);
        b_exp_t be;
        be.d = d; be.v = v;
        bq.push_back(be);
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        rstn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 12'h000; pwdata = 32'h0; pstrb = 4'h0; b_en = 1'b0; b_addr = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata0", prdata0, 32'h0);   chk("rst_pready0", 32'(pready0), 32'h0);
        chk("rst_pslverr0", 32'(pslverr0), 32'h0); chk("rst_brd0", brd0, 32'h0);
        chk("rst_prdata3", prdata3, 32'h0);   chk("rst_pready3", 32'(pready3), 32'h0);
        chk("rst_pslverr3", 32'(pslverr3), 32'h0); chk("rst_brd3", brd3, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Basic write/readback, strobes, errors, empty strobe
        apb(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        apb(0, 1'b1, 12'h020, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0);
        apb(0, 1'b1, 12'h020, 32'h11223344, 4'b0101, 1'b0, 32'h0);
        apb(0, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 32'hAA22AA44);
        apb(0, 1'b1, 12'h320, 32'h12345678, 4'hF, 1'b1, 32'h0);
        apb(0, 1'b0, 12'h320, 32'h0, 4'h0, 1'b1, 32'h0);
        apb(0, 1'b1, 12'h011, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        apb(0, 1'b0, 12'h011, 32'h0, 4'h0, 1'b1, 32'h0);
        apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        apb(0, 1'b1, 12'h010, 32'h00000000, 4'h0, 1'b0, 32'h0);
        apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

        // Collision on index 7: port B sees old 0x9, then new 0x5
        apb(0, 1'b1, 12'h01C, 32'h9, 4'hF, 1'b0, 32'h0);
        fork
            apb(0, 1'b1, 12'h01C, 32'h5, 4'hF, 1'b0, 32'h0);
            begin
                @(posedge clk); @(posedge clk); #1;
                b_en = 1'b1; b_addr = 8'd7; bpush(0, 32'h9);
                @(posedge clk); #1;
                bpush(0, 32'h5);
                @(posedge clk); #1;
                b_en = 1'b0;
            end
        join
        apb(0, 1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, 32'h5);

        // Back-to-back port-B reads, including an out-of-range index
        @(posedge clk); #1; b_en = 1'b1; b_addr = 8'd4;   bpush(0, 32'hDEADBEEF);
        @(posedge clk); #1;              b_addr = 8'd8;   bpush(0, 32'hAA22AA44);
        @(posedge clk); #1;              b_addr = 8'd210; bpush(0, 32'h0);
        @(posedge clk); #1;              b_addr = 8'd7;   bpush(0, 32'h5);
        @(posedge clk); #1; b_en = 1'b0; b_addr = 8'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("portb_hold", brd0, 32'h5);

        // Wait-state unit: write/readback, then watch a write commit via port B
        apb(3, 1'b1, 12'h040, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        apb(3, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
        fork
            apb(3, 1'b1, 12'h040, 32'h0BADC0DE, 4'hF, 1'b0, 32'h0);
            begin
                @(posedge clk); @(posedge clk); #1;
                b_en = 1'b1; b_addr = 8'd16; bpush(3, 32'hCAFEF00D);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    bpush(3, 32'hCAFEF00D);
                end
                @(posedge clk); #1;
                bpush(3, 32'h0BADC0DE);
                @(posedge clk); #1;
                b_en = 1'b0;
            end
        join

        // Reset during the second wait cycle of a write
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040;
        pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_prdata3", prdata3, 32'h0);    chk("midrst_pready3", 32'(pready3), 32'h0);
        chk("midrst_pslverr3", 32'(pslverr3), 32'h0); chk("midrst_brd3", brd3, 32'h0);
        chk("midrst_prdata0", prdata0, 32'h0);    chk("midrst_brd0", brd0, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1; psel3 = 1'b0; penable = 1'b0;
        apb(3, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, 32'h0BADC0DE);
        apb(0, 1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, 32'h5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_apb_drain", 32'(aq.size()), 32'h0);
        chk("sb_portb_drain", 32'(bq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
